// File: rtl/muldiv_hilo_unit.sv
// Iterative unsigned multiply/divide unit that owns the HI/LO register pair.
// MULTU uses a radix-2 shift-add loop and DIVU uses a restoring divider.
// Each does one step per cycle for XLEN cycles. HI/LO change only on
// completion, and a stall is requested while an operation is in flight.
module muldiv_hilo_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            mf_req,
    output logic            busy,
    output logic            done,
    output logic            stall_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // a_q: multiplicand (MUL) or dividend shifted out MSB-first (DIV).
    // b_q: multiplier shifted out LSB-first (MUL) or divisor (DIV).
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    // acc_q: partial product (MUL), or {rem, quo} (DIV).
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    // Datapath for a single iteration of either algorithm.
    logic [XLEN:0]     mul_sum;   // upper half plus carry-out extension
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     div_sh;    // remainder shifted left with the next dividend bit
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_acc;
    logic              last_step;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh    = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
    assign div_diff  = div_sh - {1'b0, b_q};
    assign div_ok    = ~div_diff[XLEN];
    assign div_rem   = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_acc   = {div_rem, acc_q[XLEN-2:0], div_ok};
    assign last_step = (cnt_q == CNT_W'(XLEN - 1));

    // Next-state logic: issue, per-cycle iteration, and result write-back.
    always_comb begin
        // NOTE: every _d gets a hold value first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = op_div ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d    = mul_acc[2*XLEN-1:XLEN];
                    lo_d    = mul_acc[XLEN-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_acc;
                a_d   = a_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d    = div_acc[2*XLEN-1:XLEN];
                    lo_d    = div_acc[XLEN-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation and clears HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers sample pre-edge values together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign stall_req = busy & (start | mf_req);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit. Inputs change and outputs are
// sampled on the falling clock edge. All expected values are hand-computed.
module tb_muldiv_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mf_req;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

    muldiv_hilo_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_div    (op_div),
        .op_a      (op_a),
        .op_b      (op_b),
        .mf_req    (mf_req),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present a start for one cycle; on return busy should be high (cycle 1).
    task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op_div = div;
        op_a   = a;
        op_b   = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Count busy cycles (bounded), confirming HI/LO stay put while busy.
    task automatic wait_done(input string tag, output int n);
        logic [31:0] hi0, lo0;
        logic        stable;
        hi0    = hi;
        lo0    = lo;
        stable = 1'b1;
        n      = 0;
        while (busy && n < 40) begin
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        check({tag, " hilo_stable"}, 64'(stable), 64'd1);
    endtask

    int n;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op_div = 1'b0;
        op_a   = '0;
        op_b   = '0;
        mf_req = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi",   64'(hi),   64'd0);
        check("reset lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU all-ones squared.
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul1 busy", 64'(busy), 64'd1);
        wait_done("mul1", n);
        check("mul1 latency", 64'(n),    64'd32);
        check("mul1 done",    64'(done), 64'd1);
        check("mul1 hi",      64'(hi),   64'hFFFF_FFFE);
        check("mul1 lo",      64'(lo),   64'h0000_0001);
        @(negedge clk);
        check("mul1 done_pulse", 64'(done), 64'd0);

        // DIVU 100 / 7; previous HI/LO held during busy.
        issue(1'b1, 32'd100, 32'd7);
        wait_done("div1", n);
        check("div1 latency", 64'(n),    64'd32);
        check("div1 done",    64'(done), 64'd1);
        check("div1 lo",      64'(lo),   64'd14);
        check("div1 hi",      64'(hi),   64'd2);
        @(negedge clk);

        // DIVU by zero.
        issue(1'b1, 32'h1234_5678, 32'd0);
        wait_done("div0", n);
        check("div0 latency", 64'(n),  64'd32);
        check("div0 lo",      64'(lo), 64'hFFFF_FFFF);
        check("div0 hi",      64'(hi), 64'h1234_5678);
        @(negedge clk);

        // MULTU 3*5 with mf_req held from cycle 2.
        issue(1'b0, 32'd3, 32'd5);
        #1;
        check("mf cycle1 stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        mf_req = 1'b1;
        #1;
        check("mf cycle2 stall", 64'(stall_req), 64'd1);
        @(negedge clk);
        n = 2;
        while (busy && n < 40) begin
            if (stall_req !== 1'b1) check("mf stall_hold", 64'(stall_req), 64'd1);
            n++;
            @(negedge clk);
        end
        check("mf latency",    64'(n),         64'd32);
        check("mf done",       64'(done),      64'd1);
        check("mf done_stall", 64'(stall_req), 64'd0);
        check("mf lo",         64'(lo),        64'd15);
        check("mf hi",         64'(hi),        64'd0);
        mf_req = 1'b0;
        @(negedge clk);

        // MULTU 6*7, DIVU 9/2 tried at cycle 10 (ignored), retried in done cycle.
        issue(1'b0, 32'd6, 32'd7);
        n = 1;
        while (busy && n < 40) begin
            if (n == 10) begin
                start  = 1'b1;
                op_div = 1'b1;
                op_a   = 32'd9;
                op_b   = 32'd2;
                #1;
                check("retry busy_stall", 64'(stall_req), 64'd1);
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        check("retry mul_latency", 64'(n - 1), 64'd32);
        check("retry mul_done",    64'(done),  64'd1);
        check("retry mul_lo",      64'(lo),    64'd42);
        check("retry mul_hi",      64'(hi),    64'd0);
        issue(1'b1, 32'd9, 32'd2);
        check("retry div_busy", 64'(busy), 64'd1);
        wait_done("retry div", n);
        check("retry div_latency", 64'(n),  64'd32);
        check("retry div_lo",      64'(lo), 64'd4);
        check("retry div_hi",      64'(hi), 64'd1);
        @(negedge clk);

        // Reset at cycle 16 of a MULTU aborts it with no later done.
        issue(1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (15) @(negedge clk);
        check("abort busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi",   64'(hi),   64'd0);
        check("abort lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        check("abort no_done", 64'(n),  64'd0);
        check("abort hi_after", 64'(hi), 64'd0);
        check("abort lo_after", 64'(lo), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
